mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/Def.svh | 6 +
 rtl/mem_arb_select.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the fetch/data memory port arbiter.
`include "Def.svh"

package mem_arb_pkg;

    localparam int ADDR_W           = `ADDR_SIZE;
    localparam int DATA_W           = `DATA_SIZE;
    localparam int MAX_D_STREAK_DEF = 4;
    localparam int TIMEOUT_DEF      = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory command/response signals.
`include "Def.svh"

interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/Def.svh
// Global address and data widths shared by the arbiter, its interface and the bench.
`ifndef DEF_SVH
`define DEF_SVH
`define ADDR_SIZE 16
`define DATA_SIZE 16
`endif

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data ports, with a data-streak counter that
// lets a waiting fetch through after MAX_D_STREAK consecutive data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   grant_en,
    input  logic   i_req,
    input  logic   d_req,
    output logic   gnt_valid,
    output owner_e gnt_owner
);

    localparam int            SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    // Data wins unless the fetch port has waited through a full streak.
    always_comb begin
        gnt_valid = i_req | d_req;
        if (i_req && (!d_req || (streak_q == STREAK_MAX))) begin
            gnt_owner = OWN_FETCH;
        end else begin
            gnt_owner = OWN_DATA;
        end
    end

    // Streak only grows while fetch is actually being held off.
    always_comb begin
        streak_d = streak_q;
        if (grant_en && gnt_valid) begin
            if (gnt_owner == OWN_FETCH) begin
                streak_d = {SW{1'b0}};
            end else if (!i_req) begin
                streak_d = {SW{1'b0}};
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + SW'(1);
            end else begin
                streak_d = streak_q;
            end
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= {SW{1'b0}};
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory: IDLE grants,
// BUSY holds the latched command until mem_ready or timeout, RESP pulses the ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              mem_req_q, mem_req_d;

    logic              gnt_valid_s;
    owner_e            gnt_owner_s;
    logic [DATA_W-1:0] rd_val_s;

    mem_arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_select (
        .clk       (clk),
        .reset     (reset),
        .grant_en  (state_q == ST_IDLE),
        .i_req     (bus.i_req),
        .d_req     (bus.d_req),
        .gnt_valid (gnt_valid_s),
        .gnt_owner (gnt_owner_s)
    );

    // A timed-out read returns zero rather than whatever is on the bus.
    assign rd_val_s = bus.mem_ready ? bus.mem_rdata : {DATA_W{1'b0}};

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        mem_req_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (gnt_valid_s) begin
                    owner_d   = gnt_owner_s;
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
                    if (gnt_owner_s == OWN_FETCH) begin
                        we_d    = 1'b0;
                        addr_d  = bus.i_addr;
                        wdata_d = {DATA_W{1'b0}};
                    end else begin
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready || (cnt_q == TO_LAST)) begin
                    state_d = ST_RESP;
                    cnt_d   = {CW{1'b0}};
                    if (!bus.mem_ready) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (owner_q == OWN_FETCH) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rd_val_s;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = rd_val_s;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_FETCH;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            cnt_q     <= {CW{1'b0}};
            err_q     <= 1'b0;
            i_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q <= {DATA_W{1'b0}};
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs are driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_D_STREAK (4),
        .TIMEOUT      (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h want 0", bus.mem_req); end
        checks++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got i=%0h d=%0h want 0 0", bus.i_ack, bus.d_ack); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h want 0", bus.err); end
        checks++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got i=%0h d=%0h want 0 0", bus.i_rdata, bus.d_rdata); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin errors++; $display("FAIL reset_cmd: got we=%0h a=%0h wd=%0h want 0 0 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_fetch_read();
        bus.i_req  = 1'b1;
        bus.i_addr = ADDR_W'(3);
        step();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== ADDR_W'(3) || bus.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_cmd: got req=%0h a=%0h we=%0h want 1 3 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DATA_W'(16'h1234);
        step();
        checks++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack: got i=%0h d=%0h want 1 0", bus.i_ack, bus.d_ack); end
        checks++; if (bus.i_rdata !== DATA_W'(16'h1234)) begin errors++; $display("FAIL fetch_rdata: got %0h want 1234", bus.i_rdata); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_resp_mem_req: got %0h want 0", bus.mem_req); end
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        checks++; if (bus.i_ack !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_idle: got ack=%0h req=%0h want 0 0", bus.i_ack, bus.mem_req); end
    endtask

    task automatic test_simultaneous();
        bus.i_req   = 1'b1;
        bus.i_addr  = ADDR_W'(3);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = ADDR_W'(7);
        bus.d_wdata = DATA_W'(16'h00AB);
        step();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(7) || bus.mem_wdata !== DATA_W'(16'h00AB)) begin errors++; $display("FAIL simul_data_first: got we=%0h a=%0h wd=%0h want 1 7 ab", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DATA_W'(16'hEEEE);
        step();
        checks++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin errors++; $display("FAIL simul_d_ack: got d=%0h i=%0h want 1 0", bus.d_ack, bus.i_ack); end
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        step();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== ADDR_W'(3) || bus.mem_we !== 1'b0) begin errors++; $display("FAIL simul_fetch_next: got req=%0h a=%0h we=%0h want 1 3 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DATA_W'(16'h4321);
        step();
        checks++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0 || bus.i_rdata !== DATA_W'(16'h4321)) begin errors++; $display("FAIL simul_i_ack: got i=%0h d=%0h rd=%0h want 1 0 4321", bus.i_ack, bus.d_ack, bus.i_rdata); end
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_anti_starvation();
        bus.i_req  = 1'b1;
        bus.i_addr = ADDR_W'(16'h0010);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = ADDR_W'(16'h0020);
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (bus.mem_addr !== ((k == 4) ? ADDR_W'(16'h0010) : ADDR_W'(16'h0020))) begin errors++; $display("FAIL starve_grant%0d: got addr %0h want %0h", k, bus.mem_addr, (k == 4) ? 16'h0010 : 16'h0020); end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = DATA_W'(k);
            step();
            checks++; if (bus.i_ack !== (k == 4) || bus.d_ack !== (k != 4)) begin errors++; $display("FAIL starve_ack%0d: got i=%0h d=%0h want %0h %0h", k, bus.i_ack, bus.d_ack, (k == 4), (k != 4)); end
            bus.mem_ready = 1'b0;
            step();
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();
    endtask

    task automatic test_write_keeps_rdata();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = ADDR_W'(9);
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DATA_W'(16'h0055);
        step();
        checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== DATA_W'(16'h0055)) begin errors++; $display("FAIL wr_first_read: got ack=%0h rd=%0h want 1 55", bus.d_ack, bus.d_rdata); end
        bus.d_we      = 1'b1;
        bus.d_wdata   = DATA_W'(16'h00AA);
        bus.mem_ready = 1'b0;
        step();
        step();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(9) || bus.mem_wdata !== DATA_W'(16'h00AA)) begin errors++; $display("FAIL wr_cmd: got we=%0h a=%0h wd=%0h want 1 9 aa", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DATA_W'(16'h00EE);
        step();
        checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== DATA_W'(16'h0055)) begin errors++; $display("FAIL wr_keeps_rdata: got ack=%0h rd=%0h want 1 55", bus.d_ack, bus.d_rdata); end
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = ADDR_W'(16'h0030);
        bus.mem_ready = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step();
        end
        checks++; if (bus.mem_req !== 1'b1 || bus.d_ack !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL to_busy15: got req=%0h ack=%0h err=%0h want 1 0 0", bus.mem_req, bus.d_ack, bus.err); end
        step();
        checks++; if (bus.d_ack !== 1'b1 || bus.err !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_resp: got ack=%0h err=%0h req=%0h want 1 1 0", bus.d_ack, bus.err, bus.mem_req); end
        checks++; if (bus.d_rdata !== '0) begin errors++; $display("FAIL to_rdata: got %0h want 0", bus.d_rdata); end
        bus.d_req = 1'b0;
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = ADDR_W'(16'h0044);
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DATA_W'(16'h0099);
        step();
        checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== DATA_W'(16'h0099) || bus.err !== 1'b1) begin errors++; $display("FAIL to_next: got ack=%0h rd=%0h err=%0h want 1 99 1", bus.i_ack, bus.i_rdata, bus.err); end
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_busy();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = ADDR_W'(5);
        step();
        step();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy2: got req=%0h want 1", bus.mem_req); end
        reset = 1'b1;
        step();
        checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0 || bus.err !== 1'b0 || bus.mem_addr !== '0) begin errors++; $display("FAIL rst_abort: got req=%0h ack=%0h err=%0h a=%0h want 0 0 0 0", bus.mem_req, bus.d_ack, bus.err, bus.mem_addr); end
        reset = 1'b0;
        step();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== ADDR_W'(5) || bus.d_ack !== 1'b0) begin errors++; $display("FAIL rst_regrant: got req=%0h a=%0h ack=%0h want 1 5 0", bus.mem_req, bus.mem_addr, bus.d_ack); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = DATA_W'(16'h0077);
        step();
        checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== DATA_W'(16'h0077)) begin errors++; $display("FAIL rst_complete: got ack=%0h rd=%0h want 1 77", bus.d_ack, bus.d_rdata); end
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_read();
        test_simultaneous();
        test_anti_starvation();
        test_write_keeps_rdata();
        test_timeout();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
